// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front-end and core: default widths,
// controller state encoding and the reset coefficient set.
package fir_pkg;

    localparam int FIR_DATA_W  = 8;
    localparam int FIR_N_COEFF = 3;
    localparam int FIR_DIV_W   = 8;

    // Entry 0 sits in the LSBs; the FIR core resets to the same set.
    localparam logic [FIR_N_COEFF*FIR_DATA_W-1:0] FIR_DEF_COEFF = {8'd0, 8'd0, 8'd0};

    typedef enum logic [1:0] {
        STREAM = 2'd0,
        LOAD   = 2'd1,
        GAP    = 2'd2
    } fir_state_e;

endpackage

// File: rtl/fir_input_ctrl_if.sv
// Sample, configuration and FIR-facing signals of the input controller.
// The master side is the host/sample source; the slave side is fir_input_ctrl.
interface fir_input_ctrl_if
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W
);

    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     cfg_wr;
    logic [1:0]               cfg_addr;
    logic signed [DATA_W-1:0] cfg_data;
    logic                     cfg_commit;

    logic signed [DATA_W-1:0] fir_x_n;
    logic                     fir_tvalid;
    logic                     fir_set_coeffs;

    modport master (
        output in_data, in_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
        input  fir_x_n, fir_tvalid, fir_set_coeffs
    );

    modport slave (
        input  in_data, in_valid, cfg_wr, cfg_addr, cfg_data, cfg_commit,
        output fir_x_n, fir_tvalid, fir_set_coeffs
    );

endinterface

// File: rtl/fir_rate_div.sv
// Input-rate divider: tick once every rate_div+1 cycles, with a synchronous
// clear that restarts the count from zero.
module fir_rate_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] rate_div,
    input  logic             clr,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // A count already above a freshly lowered rate_div wraps through all-ones.
    assign tick = (count == rate_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fir_input_ctrl.sv
// FIR front end: decimates the sample stream and replays the shadow
// coefficient bank into the FIR on a commit request.
module fir_input_ctrl
    import fir_pkg::*;
#(
    parameter int                        DATA_W    = FIR_DATA_W,
    parameter int                        N_COEFF   = FIR_N_COEFF,
    parameter int                        DIV_W     = FIR_DIV_W,
    parameter logic [N_COEFF*DATA_W-1:0] DEF_COEFF = FIR_DEF_COEFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] rate_div,
    fir_input_ctrl_if.slave  bus,
    output logic             busy,
    output logic             cfg_err,
    output logic [7:0]       drop_cnt
);

    localparam int               IDX_W    = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEFF - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    fir_state_e               state, state_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic                     tick;
    logic                     div_clr;
    logic                     wr_ok;
    logic                     cfg_bad;
    logic signed [DATA_W-1:0] shadow     [N_COEFF];
    logic signed [DATA_W-1:0] shadow_fwd [N_COEFF];
    logic signed [DATA_W-1:0] x_n_nxt;
    logic                     tvalid_nxt;
    logic                     set_nxt;
    logic                     busy_nxt;

    fir_rate_div #(
        .DIV_W (DIV_W)
    ) u_rate_div (
        .clk      (clk),
        .reset    (reset),
        .rate_div (rate_div),
        .clr      (div_clr),
        .tick     (tick)
    );

    assign wr_ok   = bus.cfg_wr && (state == STREAM) && (32'(bus.cfg_addr) < N_COEFF);
    assign cfg_bad = bus.cfg_wr && !wr_ok;

    // Same-cycle write is forwarded so a commit snapshots the updated bank.
    always_comb begin
        for (int i = 0; i < N_COEFF; i++) begin
            shadow_fwd[i] = (wr_ok && (32'(bus.cfg_addr) == i)) ? bus.cfg_data : shadow[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_COEFF; i++) begin
                shadow[i] <= DEF_COEFF[i*DATA_W +: DATA_W];
            end
        end else begin
            for (int i = 0; i < N_COEFF; i++) begin
                shadow[i] <= shadow_fwd[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= STREAM;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Output values are computed for the state being entered, so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        div_clr    = 1'b0;
        x_n_nxt    = bus.in_data;
        tvalid_nxt = 1'b0;
        set_nxt    = 1'b0;
        busy_nxt   = 1'b0;
        case (state)
            STREAM: begin
                tvalid_nxt = bus.in_valid & tick;
                if (bus.cfg_commit) begin
                    state_nxt  = LOAD;
                    idx_nxt    = '0;
                    tvalid_nxt = 1'b0;
                    set_nxt    = 1'b1;
                    busy_nxt   = 1'b1;
                    x_n_nxt    = shadow_fwd[0];
                end
            end
            LOAD: begin
                busy_nxt = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = GAP;
                    x_n_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                    set_nxt = 1'b1;
                    x_n_nxt = shadow[idx + 1'b1];
                end
            end
            GAP: begin
                state_nxt = STREAM;
                div_clr   = 1'b1;
                x_n_nxt   = '0;
            end
            default: begin
                state_nxt = STREAM;
            end
        endcase
    end

    // Output register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.fir_x_n        <= '0;
            bus.fir_tvalid     <= 1'b0;
            bus.fir_set_coeffs <= 1'b0;
            busy               <= 1'b0;
            cfg_err            <= 1'b0;
            drop_cnt           <= '0;
        end else begin
            bus.fir_x_n        <= x_n_nxt;
            bus.fir_tvalid     <= tvalid_nxt;
            bus.fir_set_coeffs <= set_nxt;
            busy               <= busy_nxt;
            if (cfg_bad) begin
                cfg_err <= 1'b1;
            end
            if ((state != STREAM) && bus.in_valid) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_fir_input_ctrl.sv
// Randomised bench for fir_input_ctrl against a queue-based model of the
// stream / load-burst behaviour.
module tb_fir_input_ctrl;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rate_div;
    logic       busy;
    logic       cfg_err;
    logic [7:0] drop_cnt;

    fir_input_ctrl_if bus ();

    fir_input_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .rate_div (rate_div),
        .bus      (bus),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       set;
        logic       tv;
        logic       bsy;
        logic       chk_x;
        logic [7:0] x;
    } exp_t;

    exp_t       burst_q[$];
    exp_t       exp_o;
    logic [7:0] m_shadow [N];
    int         m_cnt;
    int         busy_left;
    int         m_drops;
    logic       m_err;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] fwd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        burst_q.delete();
        busy_left = 0;
        m_cnt     = 0;
        m_drops   = 0;
        m_err     = 1'b0;
        for (int i = 0; i < N; i++) m_shadow[i] = 8'd0;
        exp_o = '{set: 1'b0, tv: 1'b0, bsy: 1'b0, chk_x: 1'b1, x: 8'd0};
    endfunction

    // One clock of the reference: expected outputs after this edge.
    function automatic void model_step();
        logic tick;
        if (busy_left > 0) begin
            if (bus.in_valid && m_drops < 255) m_drops++;
            if (bus.cfg_wr) m_err = 1'b1;
            busy_left--;
            if (burst_q.size() > 0) begin
                exp_o = burst_q.pop_front();
            end else begin
                exp_o = '{set: 1'b0, tv: 1'b0, bsy: 1'b0, chk_x: 1'b0, x: 8'd0};
                m_cnt = 0;
            end
        end else begin
            if (bus.cfg_wr) begin
                if (int'(bus.cfg_addr) < N) m_shadow[bus.cfg_addr] = bus.cfg_data;
                else m_err = 1'b1;
            end
            tick  = (m_cnt == int'(rate_div));
            m_cnt = tick ? 0 : (m_cnt + 1) % 256;
            if (bus.cfg_commit) begin
                for (int i = 0; i < N; i++)
                    burst_q.push_back('{set: 1'b1, tv: 1'b0, bsy: 1'b1, chk_x: 1'b1, x: m_shadow[i]});
                burst_q.push_back('{set: 1'b0, tv: 1'b0, bsy: 1'b1, chk_x: 1'b1, x: 8'd0});
                busy_left = N + 1;
                exp_o = burst_q.pop_front();
            end else begin
                exp_o = '{set: 1'b0, tv: bus.in_valid & tick, bsy: 1'b0, chk_x: 1'b1, x: bus.in_data};
            end
        end
    endfunction

    task automatic check_outputs();
        chk("tvalid", {31'd0, bus.fir_tvalid}, {31'd0, exp_o.tv});
        chk("set_coeffs", {31'd0, bus.fir_set_coeffs}, {31'd0, exp_o.set});
        chk("busy", {31'd0, busy}, {31'd0, exp_o.bsy});
        if (exp_o.chk_x) chk("x_n", {24'd0, bus.fir_x_n}, {24'd0, exp_o.x});
        chk("cfg_err", {31'd0, cfg_err}, {31'd0, m_err});
        chk("drop_cnt", {24'd0, drop_cnt}, 32'(m_drops));
        chk("set_and_tvalid", {31'd0, bus.fir_set_coeffs & bus.fir_tvalid}, 32'd0);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic wr,
                        input logic [1:0] a, input logic [7:0] cd, input logic cm);
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.cfg_wr     = wr;
        bus.cfg_addr   = a;
        bus.cfg_data   = cd;
        bus.cfg_commit = cm;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input logic v, input logic [7:0] d);
        step(v, d, 1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    // Called just after a falling edge; checks outputs clear before the next rising edge.
    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_commit = 1'b0;
        #1 reset = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b0;
        rate_div       = 8'd0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_addr   = 2'd0;
        bus.cfg_data   = '0;
        bus.cfg_commit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b1;

        // Full-rate pass-through
        idle(1'b1, 8'd0);
        idle(1'b1, 8'd1);
        idle(1'b1, 8'd0);
        for (int i = 0; i < 5; i++) idle(1'b1, 8'($urandom));

        // Divide by 4 with in_data = cycle number
        rate_div = 8'd3;
        for (int c = 0; c < 16; c++) begin
            idle(1'b1, 8'(c));
            if (bus.fir_tvalid) fwd.push_back(bus.fir_x_n);
        end
        chk("fwd_count", 32'(fwd.size()), 32'd4);
        if (fwd.size() >= 3) begin
            chk("fwd_0", {24'd0, fwd[0]}, 32'd3);
            chk("fwd_1", {24'd0, fwd[1]}, 32'd7);
            chk("fwd_2", {24'd0, fwd[2]}, 32'd11);
        end

        // Lower rate_div below the running count: count wraps through 255
        rate_div = 8'd10;
        for (int i = 0; i < 20 && m_cnt != 6; i++) idle(1'($urandom), 8'($urandom));
        rate_div = 8'd2;
        for (int i = 0; i < 270; i++) idle(1'($urandom), 8'($urandom));

        // Commit 1,2,3 with in_valid held and a second commit inside LOAD
        rate_div = 8'd0;
        step(1'b0, 8'd0, 1'b1, 2'd0, 8'd1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 2'd1, 8'd2, 1'b0);
        step(1'b0, 8'd0, 1'b1, 2'd2, 8'd3, 1'b0);
        step(1'b1, 8'd40, 1'b0, 2'd0, 8'd0, 1'b1);
        idle(1'b1, 8'd41);
        step(1'b1, 8'd42, 1'b0, 2'd0, 8'd0, 1'b1);
        idle(1'b1, 8'd43);
        idle(1'b1, 8'd44);
        idle(1'b1, 8'd45);
        chk("drop_after_commit", {24'd0, drop_cnt}, 32'd4);

        // Bad address sets the sticky error
        step(1'b0, 8'd0, 1'b1, 2'd3, 8'd55, 1'b0);
        chk("err_bad_addr", {31'd0, cfg_err}, 32'd1);
        idle(1'b0, 8'd0);
        chk("err_sticky", {31'd0, cfg_err}, 32'd1);

        // Write during LOAD is rejected; same-cycle write with commit is taken
        do_reset();
        step(1'b0, 8'd0, 1'b1, 2'd0, 8'd1, 1'b0);
        step(1'b0, 8'd0, 1'b1, 2'd1, 8'd2, 1'b0);
        step(1'b0, 8'd0, 1'b1, 2'd2, 8'd3, 1'b0);
        step(1'b0, 8'd0, 1'b1, 2'd1, 8'd7, 1'b1);
        step(1'b0, 8'd0, 1'b1, 2'd0, 8'd99, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0, 8'd0);
        chk("err_during_load", {31'd0, cfg_err}, 32'd1);
        step(1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1, 8'($urandom));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) rate_div = 8'($urandom_range(0, 3));
            step(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
                 2'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
        end

        // Drop counter saturation
        rate_div = 8'd0;
        for (int k = 0; k < 70; k++) begin
            step(1'b1, 8'($urandom), 1'b0, 2'd0, 8'd0, 1'b1);
            for (int i = 0; i < 4; i++) idle(1'b1, 8'($urandom));
        end
        chk("drop_saturated", {24'd0, drop_cnt}, 32'd255);

        // Reset in the second LOAD cycle, then replay the default bank
        step(1'b0, 8'd0, 1'b1, 2'd0, 8'd9, 1'b1);
        idle(1'b0, 8'd0);
        chk("in_load_before_reset", {31'd0, bus.fir_set_coeffs}, 32'd1);
        do_reset();
        step(1'b0, 8'd0, 1'b0, 2'd0, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1, 8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
